armleo_response_router: RTL and testbench
=========================================

Name: armleo_response_router

Overview:
- Return-path companion to the round-robin request arbiter.
- Records, in order, the grant index of every transaction the arbiter issues to a shared responder.
- Routes each response from that responder back to the requester port that issued it.
- Responses return strictly in issue order; one response per issued transaction.

Parameters:
- WIDTH, 4: number of requester ports; matches the arbiter WIDTH.
- DEPTH, 4: maximum outstanding transactions (FIFO entries); power of two, ≥2.
- DATA_WIDTH, 32: response payload width.
- IDX_W (localparam): $clog2(WIDTH).
- CNT_W (localparam): $clog2(DEPTH+1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- issue_valid  input  1  arbiter issued a transaction this cycle (grant accepted)
- issue_idx  input  IDX_W  grant index of the issued transaction
- issue_ready  output  1  tracker can accept an issue (not full)
- rsp_valid  input  1  shared responder presents a response
- rsp_data  input  DATA_WIDTH  response payload
- rsp_ready  output  1  response consumed this cycle
- out_valid  output  WIDTH  one-hot per-port response valid
- out_ready  input  WIDTH  per-port response ready
- out_data  output  DATA_WIDTH  payload, broadcast to all ports
- outstanding  output  CNT_W  number of transactions in flight (registered)
- orphan_err  output  1  sticky: a response arrived with nothing outstanding

Behaviour:
- Storage:
  - DEPTH-entry FIFO of IDX_W-bit indices.
  - Write pointer, read pointer and count are all registers.
  - Pointers wrap modulo DEPTH.
- Reset (rst_n=0 at posedge clk):
  - Pointers, count and orphan_err are cleared to 0.
  - Entry contents are don't-care.
  - Combinational outputs after reset: issue_ready=1, rsp_ready=0, out_valid=0.
  - A reset mid-operation discards all outstanding entries; responses pending at that time are not routed.
- Push:
  - issue_ready = (count != DEPTH).
  - A push occurs when issue_valid && issue_ready; issue_idx is written at the write pointer and the pointer increments.
  - issue_valid while full is a protocol violation. The push is ignored and no state changes; the upstream side must gate its ack on issue_ready.
- Route (combinational):
  - empty = (count == 0); head = FIFO[rd_ptr].
  - out_valid[i] = rsp_valid && !empty && (head == i); all other bits are 0.
  - out_data = rsp_data.
  - rsp_ready = !empty && out_ready[head].
  - rsp_ready does not depend on rsp_valid.
  - Ports other than head never see valid, even when their own ready is high.
- Pop:
  - A pop occurs when rsp_valid && rsp_ready.
  - The read pointer increments; the next response goes to the new head.
- Count:
  - Next count = count + push − pop.
  - A simultaneous push and pop leaves count unchanged; this is legal at any fill level, including full-1 and full (when full, push is blocked, so only the pop applies).
- No same-cycle bypass:
  - A transaction pushed in cycle N is visible at head no earlier than cycle N+1.
  - When empty, a push and a response in the same cycle give rsp_ready=0; the response is taken in a later cycle.
- Orphan response:
  - rsp_valid && empty sets orphan_err at the next posedge.
  - orphan_err holds until reset.
  - rsp_ready stays 0, so the response is stalled, not dropped.
- outstanding = count, registered; updates the cycle after a push or pop.
- Handshake rules:
  - Valid/ready on the response side: the responder holds rsp_valid and rsp_data stable until rsp_ready.
  - The router never withdraws out_valid while rsp_valid is held, because head changes only on a pop.
- Latency: zero-cycle combinational path from rsp_* and out_ready to the out_* and rsp_ready signals; one cycle from issue to routable.

Test Plan:
- Reset, then push idx 2 → next cycle outstanding=1; rsp_valid=1, out_ready=4'b0100 → out_valid=4'b0100, rsp_ready=1; next cycle outstanding=0.
- Push 1,3,0,2 (DEPTH=4) → issue_ready=0, outstanding=4; extra issue_valid is ignored. Responses with all out_ready=1 route to 4'b0010, 4'b1000, 4'b0001, 4'b0100 in that order.
- Head idx 3, out_ready=4'b0111, rsp_valid=1 → out_valid=4'b1000, rsp_ready=0, held 5 cycles with no pop. Raise out_ready[3] → pop in that cycle.
- Full FIFO, then push idx 1 together with a pop in the same cycle → push ignored (full), count=3. Next cycle push+pop together → count stays 3 and the pointers wrap correctly over 10 iterations.
- Empty FIFO, rsp_valid=1 → rsp_ready=0, out_valid=0, orphan_err=1 next cycle and still 1 after a later push/pop; rst_n=0 clears it.
- Three outstanding, assert rst_n=0 for 1 cycle → outstanding=0, issue_ready=1, rsp_ready=0 with rsp_valid=1, and orphan_err then sets.

Source files
------------

// File: rtl/armleo_response_router.sv
`default_nettype none
// ============================================================================
//  Module      : armleo_response_router
//  Description : Tracks grant indices of issued transactions in order and
//                routes each in-order response back to its requester port.
//  Revision    : 1.0 - initial release
// ============================================================================
module armleo_response_router #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 32,
    localparam int IDX_W      = $clog2(WIDTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_idx,
    output logic                  issue_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_ready,
    output logic [WIDTH-1:0]      out_valid,
    input  logic [WIDTH-1:0]      out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  orphan_err
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [IDX_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             orphan_q, orphan_d;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_head;

    assign w_empty     = (count_q == '0);
    assign w_head      = fifo_q[rd_ptr_q];
    assign issue_ready = (count_q != C_FULL);
    // Ready is gated by the head port only, so non-head ports cannot drain it.
    assign rsp_ready   = !w_empty && out_ready[w_head];
    assign w_push      = issue_valid && issue_ready;
    assign w_pop       = rsp_valid && rsp_ready;
    assign out_data    = rsp_data;
    assign outstanding = count_q;
    assign orphan_err  = orphan_q;

    always_comb begin
        out_valid = '0;
        if (rsp_valid && !w_empty) begin
            out_valid[w_head] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        orphan_d = orphan_q || (rsp_valid && w_empty);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    // Entry storage needs no reset; occupancy is governed by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= issue_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_armleo_response_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_armleo_response_router
//  Description : Self-checking bench with an in-order queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_armleo_response_router;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic [1:0]      issue_idx = '0;
    logic            issue_ready;
    logic            rsp_valid = 1'b0;
    logic [DW-1:0]   rsp_data = '0;
    logic            rsp_ready;
    logic [WIDTH-1:0] out_valid;
    logic [WIDTH-1:0] out_ready = '0;
    logic [DW-1:0]   out_data;
    logic [2:0]      outstanding;
    logic            orphan_err;

    int n_chk  = 0;
    int n_fail = 0;

    armleo_response_router #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of outstanding grant indices.
    int unsigned q[$];
    bit          m_orph = 1'b0;
    bit          mon_en = 1'b0;
    bit          m_pop, m_push;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_orph = 1'b0;
            mon_en = 1'b1;
        end else if (mon_en) begin
            m_pop  = rsp_valid && (q.size() > 0) && out_ready[q[0]];
            m_push = issue_valid && (q.size() < DEPTH);
            if (rsp_valid && q.size() == 0) m_orph = 1'b1;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(int'(issue_idx));
        end
    end

    logic [WIDTH-1:0] e_valid;
    logic             e_rdy;
    always @(negedge clk) begin
        if (mon_en) begin
            e_valid = '0;
            e_rdy   = 1'b0;
            if (q.size() > 0) begin
                e_rdy = out_ready[q[0]];
                if (rsp_valid) e_valid[q[0]] = 1'b1;
            end
            chk("m_issue_ready", issue_ready, q.size() != DEPTH);
            chk("m_rsp_ready",   rsp_ready,   e_rdy);
            chk("m_out_valid",   out_valid,   e_valid);
            chk("m_out_data",    out_data,    rsp_data);
            chk("m_outstanding", outstanding, q.size());
            chk("m_orphan_err",  orphan_err,  m_orph);
        end
    end

    // Apply inputs just after a posedge; they are sampled at the next one.
    task automatic drive(input bit iv, input int idx, input bit rv, input logic [3:0] ordy);
        @(posedge clk);
        #1;
        issue_valid = iv;
        issue_idx   = 2'(idx);
        rsp_valid   = rv;
        rsp_data    = $urandom;
        out_ready   = ordy;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int pushes [4];
        logic [3:0] exp_route [4];
        int guard;
        pushes    = '{1, 3, 0, 2};
        exp_route = '{4'b0010, 4'b1000, 4'b0001, 4'b0100};

        // Reset, then a single push/route of idx 2
        drive(0, 0, 0, 4'h0);
        drive(1, 2, 0, 4'h0);
        rst_n = 1'b1;
        at_neg();
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_rsp_ready",   rsp_ready,   1'b0);
        chk("rst_out_valid",   out_valid,   4'b0000);
        chk("rst_outstanding", outstanding, 3'd0);
        drive(0, 0, 1, 4'b0100);
        at_neg();
        chk("single_outstanding", outstanding, 3'd1);
        chk("single_out_valid",   out_valid,   4'b0100);
        chk("single_rsp_ready",   rsp_ready,   1'b1);
        drive(0, 0, 0, 4'h0);
        at_neg();
        chk("single_drained", outstanding, 3'd0);

        // Fill to DEPTH, then an extra issue is ignored
        for (int i = 0; i < 4; i++) drive(1, pushes[i], 0, 4'h0);
        drive(1, 1, 0, 4'h0);
        at_neg();
        chk("full_issue_ready", issue_ready, 1'b0);
        chk("full_outstanding", outstanding, 3'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 4'hF);
            at_neg();
            chk("order_route", out_valid, exp_route[i]);
        end

        // Head 3 blocked by its own ready while other ports are ready
        drive(1, 3, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 4'b0111);
            at_neg();
            chk("hold_out_valid", out_valid, 4'b1000);
            chk("hold_rsp_ready", rsp_ready, 1'b0);
        end
        drive(0, 0, 1, 4'hF);
        at_neg();
        chk("hold_release", rsp_ready, 1'b1);

        // Full with simultaneous push/pop, then steady push+pop wrapping
        for (int i = 0; i < 4; i++) drive(1, i, 0, 4'h0);
        drive(1, 1, 1, 4'hF);
        for (int i = 0; i < 10; i++) begin
            drive(1, i % 4, 1, 4'hF);
            at_neg();
            chk("wrap_outstanding", outstanding, 3'd3);
        end

        // Drain, then an orphan response
        guard = 0;
        drive(0, 0, 1, 4'hF);
        while (q.size() != 0 && guard < 20) begin
            drive(0, 0, 1, 4'hF);
            guard++;
        end
        chk("drain_timeout", guard < 20, 1'b1);
        drive(0, 0, 0, 4'hF);
        drive(0, 0, 1, 4'hF);
        at_neg();
        chk("orphan_rsp_ready", rsp_ready, 1'b0);
        chk("orphan_out_valid", out_valid, 4'b0000);
        drive(1, 0, 1, 4'hF);
        at_neg();
        chk("orphan_set", orphan_err, 1'b1);
        drive(0, 0, 1, 4'hF);
        drive(0, 0, 0, 4'h0);
        at_neg();
        chk("orphan_sticky", orphan_err, 1'b1);
        rst_n = 1'b0;
        drive(0, 0, 0, 4'h0);
        rst_n = 1'b1;
        at_neg();
        chk("orphan_cleared", orphan_err, 1'b0);

        // Reset mid-operation discards outstanding entries
        for (int i = 0; i < 3; i++) drive(1, i + 1, 0, 4'h0);
        drive(0, 0, 1, 4'h0);
        rst_n = 1'b0;
        drive(0, 0, 1, 4'hF);
        rst_n = 1'b1;
        at_neg();
        chk("midrst_outstanding", outstanding, 3'd0);
        chk("midrst_issue_ready", issue_ready, 1'b1);
        chk("midrst_rsp_ready",   rsp_ready,   1'b0);
        drive(0, 0, 0, 4'h0);
        at_neg();
        chk("midrst_orphan", orphan_err, 1'b1);

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 3),
                  $urandom_range(0, 99) < 50, 4'($urandom));
        end
        drive(0, 0, 0, 4'h0);
        at_neg();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
